// File: rtl/fetch_decode_queue.sv
// Fetch/decode decoupling queue: a small circular buffer of PC/instruction pairs
// between IF and ID. Optional stall/flush counters are enabled with FDQ_PERF_CNT_EN.
module fetch_decode_queue #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f_valid,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_instr,
   output logic                     f_ready,
   output logic                     d_valid,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_pc_plus4,
   output logic [31:0]              d_instr,
   input  logic                     d_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef FDQ_PERF_CNT_EN
   ,
   output logic [31:0]              stall_cycles,
   output logic [31:0]              flush_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   last_pc;
   logic          push;
   logic          pop;

   // Handshake: a transfer happens on a rising edge where valid & ready are both
   // high; flush overrides both sides so nothing moves in a flush cycle.
   assign f_ready = (count < DEPTH_C);
   assign d_valid = (count != '0);
   assign push    = f_valid & f_ready & ~flush;
   assign pop     = d_valid & d_ready & ~flush;

   assign occupancy  = count;
   assign d_pc       = d_valid ? pc_mem[rd_ptr] : last_pc;
   assign d_instr    = d_valid ? instr_mem[rd_ptr] : NOP_INSTR;
   assign d_pc_plus4 = d_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= f_pc;
         instr_mem[wr_ptr] <= f_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Remembers the most recent head PC so d_pc stays put while the queue is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          last_pc <= '0;
      else if (d_valid) last_pc <= pc_mem[rd_ptr];
   end

`ifdef FDQ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (d_valid && !d_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
         if (flush && flush_count != '1)                flush_count  <= flush_count + 1'b1;
      end
   end
`endif

endmodule
